musa_datapath: RTL and testbench



---
 rtl/musa_datapath.sv | 206 ++++++++++++++++++++
 tb/tb_musa_datapath.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/musa_datapath.sv
// Single-cycle MUSA datapath: imem, dmem, register bank, ALU, hardware stack and PC.
// Optional stack feature guarded by MUSA_STACK_EN; rst_n is active-high despite its name.
module musa_datapath #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_REGS    = 32,
  parameter int STACK_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en,
  input  logic                  load_sel,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [4:0]            dbg_reg_addr,
  output logic [DATA_WIDTH-1:0] dbg_reg_data,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [31:0]           instruction,
  output logic [1:0]            pc_src,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  push,
  output logic                  pop,
  output logic                  reg_write,
  output logic                  reg_dst,
  output logic [1:0]            mem_to_reg,
  output logic [2:0]            alu_op,
  output logic                  data_a_sel,
  output logic [1:0]            data_b_sel,
  output logic                  halted,
  output logic                  stack_ovf,
  output logic                  stack_unf
);
  localparam int MEM_WORDS = 1 << ADDR_WIDTH;
  localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h01, OP_LW = 6'h02, OP_SW = 6'h03,
                         OP_BEQ = 6'h04, OP_JMP = 6'h05, OP_PUSH = 6'h06, OP_POP = 6'h07,
                         OP_CALL = 6'h08, OP_RET = 6'h09, OP_HALT = 6'h3F;

  logic [31:0]           imem [MEM_WORDS];
  logic [DATA_WIDTH-1:0] dmem [MEM_WORDS];
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [5:0]            op;
  logic [4:0]            rd_a, rs_a, rt_a;
  logic [DATA_WIDTH-1:0] imm_ext, rd_val, rs_val, rt_val;
  logic [DATA_WIDTH-1:0] alu_a, alu_b, alu_res, wb_data, dmem_rd, stack_top, pc_plus1_ext;
  logic [ADDR_WIDTH-1:0] pc_plus1, pc_next, mem_addr;
  logic                  alu_zero;

  assign instruction  = imem[pc];
  assign op           = instruction[31:26];
  assign rd_a         = instruction[25:21];
  assign rs_a         = instruction[20:16];
  assign rt_a         = instruction[15:11];
  assign imm_ext      = {{(DATA_WIDTH-16){instruction[15]}}, instruction[15:0]};
  assign rd_val       = (rd_a == 5'd0) ? {DATA_WIDTH{1'b0}} : regs[rd_a];
  assign rs_val       = (rs_a == 5'd0) ? {DATA_WIDTH{1'b0}} : regs[rs_a];
  assign rt_val       = (rt_a == 5'd0) ? {DATA_WIDTH{1'b0}} : regs[rt_a];
  assign dbg_reg_data = (dbg_reg_addr == 5'd0) ? {DATA_WIDTH{1'b0}} : regs[dbg_reg_addr];
  assign pc_plus1     = pc + ADDR_WIDTH'(1);
  assign pc_plus1_ext = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, pc_plus1};
  assign mem_addr     = alu_res[ADDR_WIDTH-1:0];
  assign dmem_rd      = dmem[mem_addr];

  // Instruction decode into the exported control word
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 2'b00;
    alu_op     = 3'b000;
    data_a_sel = 1'b0;
    data_b_sel = 2'b00;
    case (op)
      OP_R:    begin reg_write = 1'b1; reg_dst = 1'b1; alu_op = instruction[2:0]; end
      OP_ADDI: begin reg_write = 1'b1; reg_dst = 1'b1; data_b_sel = 2'b01; end
      OP_LW:   begin reg_write = 1'b1; reg_dst = 1'b1; mem_read = 1'b1;
                     mem_to_reg = 2'b01; data_b_sel = 2'b01; end
      OP_SW:   begin mem_write = 1'b1; data_b_sel = 2'b01; end
      OP_BEQ:  begin alu_op = 3'b001; data_a_sel = 1'b1; data_b_sel = 2'b10; end
`ifdef MUSA_STACK_EN
      OP_PUSH: push = 1'b1;
      OP_POP:  begin pop = 1'b1; reg_write = 1'b1; reg_dst = 1'b1; mem_to_reg = 2'b10; end
      OP_CALL: begin push = 1'b1; mem_to_reg = 2'b11; end
      OP_RET:  pop = 1'b1;
`endif
      default: ;
    endcase
  end

  // ALU
  always_comb begin
    alu_a = data_a_sel ? rd_val : rs_val;
    case (data_b_sel)
      2'b00:   alu_b = rt_val;
      2'b01:   alu_b = imm_ext;
      2'b10:   alu_b = rs_val;
      default: alu_b = {DATA_WIDTH{1'b0}};
    endcase
    case (alu_op)
      3'b000:  alu_res = alu_a + alu_b;
      3'b001:  alu_res = alu_a - alu_b;
      3'b010:  alu_res = alu_a & alu_b;
      3'b011:  alu_res = alu_a | alu_b;
      3'b100:  alu_res = alu_a ^ alu_b;
      3'b101:  alu_res = ~alu_a;
      3'b110:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default: alu_res = {DATA_WIDTH{1'b0}};
    endcase
    alu_zero = (alu_res == {DATA_WIDTH{1'b0}});
  end

  // Next-PC selection; kept apart from decode so the branch compare does not loop back into it
  always_comb begin
    case (op)
      OP_BEQ:  pc_src = alu_zero ? 2'b01 : 2'b00;
      OP_JMP:  pc_src = 2'b10;
`ifdef MUSA_STACK_EN
      OP_CALL: pc_src = 2'b10;
      OP_RET:  pc_src = 2'b11;
`endif
      default: pc_src = 2'b00;
    endcase
    case (pc_src)
      2'b01:   pc_next = pc_plus1 + imm_ext[ADDR_WIDTH-1:0];
      2'b10:   pc_next = instruction[ADDR_WIDTH-1:0];
      2'b11:   pc_next = stack_top[ADDR_WIDTH-1:0];
      default: pc_next = pc_plus1;
    endcase
  end

  // Register write-back source
  always_comb begin
    case (mem_to_reg)
      2'b00:   wb_data = alu_res;
      2'b01:   wb_data = dmem_rd;
      2'b10:   wb_data = stack_top;
      default: wb_data = pc_plus1_ext;
    endcase
  end

`ifdef MUSA_STACK_EN
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = $clog2(STACK_DEPTH);
  logic [DATA_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [SPW-1:0]        sp, sp_dec;
  logic                  stack_full, stack_empty;
  logic [DATA_WIDTH-1:0] push_data;

  assign stack_full  = (sp == SPW'(STACK_DEPTH));
  assign stack_empty = (sp == {SPW{1'b0}});
  assign sp_dec      = sp - SPW'(1);
  assign stack_top   = stack_empty ? {DATA_WIDTH{1'b0}} : stack_mem[sp_dec[IW-1:0]];
  assign push_data   = (op == OP_CALL) ? pc_plus1_ext : rd_val;

  // Stack storage; a push onto a full stack is dropped
  always_ff @(posedge clk) begin
    if (!rst_n && !halted && push && !stack_full) stack_mem[sp[IW-1:0]] <= push_data;
  end

  // Stack pointer and sticky overflow/underflow flags
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sp        <= {SPW{1'b0}};
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else if (!halted) begin
      if (push) begin
        if (stack_full) stack_ovf <= 1'b1;
        else            sp <= sp + SPW'(1);
      end
      if (pop) begin
        if (stack_empty) stack_unf <= 1'b1;
        else             sp <= sp_dec;
      end
    end
  end
`else
  assign stack_top = {DATA_WIDTH{1'b0}};
  assign stack_ovf = 1'b0;
  assign stack_unf = 1'b0;
`endif

  // Memories: the load port always wins over a same-cycle store
  always_ff @(posedge clk) begin
    if (load_en && !load_sel) imem[load_addr] <= load_data[31:0];
    if (load_en && load_sel) dmem[load_addr] <= load_data;
    else if (mem_write && !rst_n && !halted) dmem[mem_addr] <= rd_val;
  end

  // PC, halt state and register bank; HALT freezes the PC until reset
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pc     <= {ADDR_WIDTH{1'b0}};
      halted <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= {DATA_WIDTH{1'b0}};
    end else if (!halted) begin
      if (op == OP_HALT) halted <= 1'b1;
      else               pc <= pc_next;
      if (reg_write && rd_a != 5'd0) regs[rd_a] <= wb_data;
    end
  end
endmodule

// File: tb/tb_musa_datapath.sv
// Directed bench for musa_datapath: hand-encoded programs with hand-computed results.
module tb_musa_datapath;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_en, load_sel;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic [4:0]  dbg_reg_addr;
  logic [31:0] dbg_reg_data, instruction;
  logic [7:0]  pc;
  logic [1:0]  pc_src, mem_to_reg, data_b_sel;
  logic [2:0]  alu_op;
  logic        mem_read, mem_write, push, pop, reg_write, reg_dst, data_a_sel;
  logic        halted, stack_ovf, stack_unf;
  int          total = 0;
  int          bad = 0;

  localparam logic [31:0] HALT = 32'hFC00_0000;

  musa_datapath dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_sel(load_sel),
    .load_addr(load_addr), .load_data(load_data), .dbg_reg_addr(dbg_reg_addr),
    .dbg_reg_data(dbg_reg_data), .pc(pc), .instruction(instruction), .pc_src(pc_src),
    .mem_read(mem_read), .mem_write(mem_write), .push(push), .pop(pop),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
    .data_a_sel(data_a_sel), .data_b_sel(data_b_sel), .halted(halted),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    dbg_reg_addr = idx;
    #1;
    check(tag, dbg_reg_data, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic sel, input logic [7:0] addr, input logic [31:0] data);
    load_en = 1'b1; load_sel = sel; load_addr = addr; load_data = data;
    @(posedge clk);
    #1;
    load_en = 1'b0;
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [2:0] funct);
    return {6'h00, rd, rs, rt, 8'h00, funct};
  endfunction

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  // Program B: store/load, both branch outcomes, SLT, jump, then stack section at 20
  task automatic run_b();
    check("b_pc0", pc, 32'd0);
    step(); step();
    check("sw_pc", pc, 32'd2);
    check("sw_mem_write", mem_write, 32'd1);
    step();
    check("lw_mem_read", mem_read, 32'd1);
    check("lw_mem_to_reg", mem_to_reg, 32'd1);
    step();
    check_reg("lw_r4", 5'd4, 32'd5);
    check("beq_taken_src", pc_src, 32'd1);
    step();
    check("beq_taken_pc", pc, 32'd7);
    check("beq_ne_src", pc_src, 32'd0);
    step();
    check("beq_ne_pc", pc, 32'd8);
    step();
    check_reg("slt_r6", 5'd6, 32'd1);
    check_reg("skip_r5", 5'd5, 32'd0);
    check("jmp_src", pc_src, 32'd2);
    step();
    check("jmp_pc", pc, 32'd20);
`ifdef MUSA_STACK_EN
    check("push_ctl", push, 32'd1);
    step();
    check("pop_ctl", pop, 32'd1);
    check("pop_m2r", mem_to_reg, 32'd2);
    step();
    check_reg("pop_r7", 5'd7, 32'd5);
    check("unf_before", stack_unf, 32'd0);
    step();
    check_reg("pop_empty_r8", 5'd8, 32'd0);
    check("unf_set", stack_unf, 32'd1);
    check("call_src", pc_src, 32'd2);
    step();
    check("call_pc", pc, 32'd30);
    check("ret_src", pc_src, 32'd3);
    step();
    check("ret_pc", pc, 32'd24);
`else
    check("nostack_push", push, 32'd0);
    check("nostack_src", pc_src, 32'd0);
    step(); step(); step();
    check("nostack_call_src", pc_src, 32'd0);
    step();
    check("nostack_pc", pc, 32'd24);
    check_reg("nostack_r7", 5'd7, 32'd0);
    check("nostack_unf", stack_unf, 32'd0);
`endif
    step();
    check("b_halted", halted, 32'd1);
    check("b_halt_pc", pc, 32'd24);
  endtask

  initial begin
    rst_n = 1'b1; load_en = 1'b0; load_sel = 1'b0; load_addr = 8'd0;
    load_data = 32'd0; dbg_reg_addr = 5'd0;

    // Program A: ADDI r1=5, ADDI r2=-3, ADD r3, HALT
    load_word(1'b0, 8'd0, enc_i(6'h01, 5'd1, 5'd0, 16'd5));
    load_word(1'b0, 8'd1, enc_i(6'h01, 5'd2, 5'd0, 16'hFFFD));
    load_word(1'b0, 8'd2, enc_r(5'd3, 5'd1, 5'd2, 3'b000));
    load_word(1'b0, 8'd3, HALT);
    check("rst_pc", pc, 32'd0);
    check("rst_halted", halted, 32'd0);
    check_reg("rst_r1", 5'd1, 32'd0);
    release_reset();
    step(); step(); step();
    check_reg("add_r3", 5'd3, 32'd2);
    check_reg("addi_r2", 5'd2, 32'hFFFF_FFFD);
    check("a_pc3", pc, 32'd3);
    check("a_not_halted_yet", halted, 32'd0);
    step();
    check("a_halted", halted, 32'd1);
    step(); step();
    check("a_pc_held", pc, 32'd3);

    // Asynchronous reset clears state without waiting for a clock edge
    rst_n = 1'b1;
    #1;
    check("async_pc", pc, 32'd0);
    check("async_halted", halted, 32'd0);
    check_reg("async_r3", 5'd3, 32'd0);

    load_word(1'b0, 8'd0, enc_i(6'h01, 5'd1, 5'd0, 16'd5));
    load_word(1'b0, 8'd1, enc_i(6'h01, 5'd2, 5'd0, 16'hFFFD));
    load_word(1'b0, 8'd2, enc_i(6'h03, 5'd1, 5'd0, 16'd10));
    load_word(1'b0, 8'd3, enc_i(6'h02, 5'd4, 5'd0, 16'd10));
    load_word(1'b0, 8'd4, enc_i(6'h04, 5'd1, 5'd1, 16'd2));
    load_word(1'b0, 8'd5, enc_i(6'h01, 5'd5, 5'd0, 16'd99));
    load_word(1'b0, 8'd6, HALT);
    load_word(1'b0, 8'd7, enc_i(6'h04, 5'd1, 5'd2, 16'd5));
    load_word(1'b0, 8'd8, enc_r(5'd6, 5'd2, 5'd1, 3'b110));
    load_word(1'b0, 8'd9, enc_i(6'h05, 5'd0, 5'd0, 16'd20));
    load_word(1'b0, 8'd20, enc_i(6'h06, 5'd1, 5'd0, 16'd0));
    load_word(1'b0, 8'd21, enc_i(6'h07, 5'd7, 5'd0, 16'd0));
    load_word(1'b0, 8'd22, enc_i(6'h07, 5'd8, 5'd0, 16'd0));
    load_word(1'b0, 8'd23, enc_i(6'h08, 5'd0, 5'd0, 16'd30));
    load_word(1'b0, 8'd24, HALT);
    load_word(1'b0, 8'd30, enc_i(6'h09, 5'd0, 5'd0, 16'd0));
    load_word(1'b1, 8'd10, 32'hDEAD_BEEF);
    release_reset();
    run_b();

    // Reset in the middle of program B, then a full rerun must match
    rst_n = 1'b1;
    #1;
    release_reset();
    step(); step(); step(); step(); step();
    check("mid_pc_before", pc, 32'd7);
    rst_n = 1'b1;
    #1;
    check("mid_pc_cleared", pc, 32'd0);
    check_reg("mid_r4_cleared", 5'd4, 32'd0);
    check("mid_unf_cleared", stack_unf, 32'd0);
    release_reset();
    run_b();

`ifdef MUSA_STACK_EN
    // Overflow: 17 pushes of 1..17 into 16 entries, then pop must return 16
    rst_n = 1'b1;
    load_word(1'b0, 8'd0, enc_i(6'h01, 5'd1, 5'd0, 16'd1));
    for (int k = 0; k < 17; k++) begin
      load_word(1'b0, 8'(1 + 2 * k), enc_i(6'h06, 5'd1, 5'd0, 16'd0));
      load_word(1'b0, 8'(2 + 2 * k), enc_i(6'h01, 5'd1, 5'd1, 16'd1));
    end
    load_word(1'b0, 8'd35, enc_i(6'h07, 5'd9, 5'd0, 16'd0));
    load_word(1'b0, 8'd36, HALT);
    release_reset();
    check("ovf_reset", stack_ovf, 32'd0);
    for (int k = 0; k < 36; k++) step();
    check("ovf_pc", pc, 32'd36);
    check("ovf_set", stack_ovf, 32'd1);
    check_reg("ovf_pop_r9", 5'd9, 32'd16);
    step();
    check("ovf_halted", halted, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
